gray_pdm_modulator: RTL and testbench

Parametrised, fully synchronous successor to the feedback gray selector. It converts a WIDTH-bit binary code into a binary-weighted pulse-density bitstream whose frame length is 2^WIDTH clocks. Slot selection uses the gray-counter toggle position: the code bit whose weight matches the toggling gray bit drives that slot. The block sits in the feedback path between the up/down feedback counter and the core's 1-bit DAC input, and supports CHANNELS independent codes on one shared slot counter with frame-aligned code updates.

---
 rtl/gray_pdm_pkg.sv | 34 +++
 rtl/gray_slot_decode.sv | 25 ++
 rtl/gray_pdm_modulator.sv | 113 +++++++++++
 tb/tb_gray_pdm_modulator.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/gray_pdm_pkg.sv
// Shared helpers for the gray-slot pulse-density modulator.
// Slot position math lives here so decode and checks agree.
package gray_pdm_pkg;

    localparam int MAX_WIDTH = 16;
    localparam int DEF_WIDTH = 10;
    localparam int SLOTS     = 1 << DEF_WIDTH;

    // Frame length for an arbitrary code width.
    function automatic int slots_of(input int width);
        return 1 << width;
    endfunction

    // Number of consecutive ones from bit 0, limited to width bits.
    // This is the gray bit that toggles on the n -> n+1 increment.
    function automatic logic [4:0] trailing_ones(
        input logic [MAX_WIDTH-1:0] n,
        input int                   width
    );
        logic [4:0] k;
        logic       run;
        k   = 5'd0;
        run = 1'b1;
        for (int i = 0; i < MAX_WIDTH; i++) begin
            if (run && (i < width) && n[i]) begin
                k = k + 5'd1;
            end else begin
                run = 1'b0;
            end
        end
        return k;
    endfunction

endpackage

// File: rtl/gray_slot_decode.sv
// Slot counter to one-hot slot position, plus wrap-slot flag.
// Purely combinational; one instance serves every channel.
import gray_pdm_pkg::*;

module gray_slot_decode #(
    parameter int WIDTH = 10
) (
    input  logic [WIDTH-1:0] n,
    output logic [WIDTH-1:0] slot,
    output logic             wrap
);

    logic [4:0] k;

    // The all-ones count owns no code bit, so its one-hot stays empty.
    always_comb begin
        wrap = &n;
        k    = trailing_ones(MAX_WIDTH'(n), WIDTH);
        slot = '0;
        for (int i = 0; i < WIDTH; i++) begin
            slot[i] = !wrap && (k == 5'(i));
        end
    end

endmodule

// File: rtl/gray_pdm_modulator.sv
// Binary-weighted PDM from gray toggle position, multi-channel,
// with a one-deep pending code and frame-aligned code swaps.
import gray_pdm_pkg::*;

module gray_pdm_modulator #(
    parameter int WIDTH    = 10,
    parameter int CHANNELS = 1
) (
    input  logic                      clk,
    input  logic                      rstb,
    input  logic                      en,
    input  logic [CHANNELS*WIDTH-1:0] code_i,
    input  logic                      code_valid_i,
    output logic                      code_ready_o,
    input  logic [CHANNELS-1:0]       invert_i,
    output logic [CHANNELS-1:0]       pdm_o,
    output logic                      frame_start_o,
    output logic [WIDTH-1:0]          gray_o
);

    logic [WIDTH-1:0]          n;
    logic [WIDTH-1:0]          n_next;
    logic [WIDTH-1:0]          slot;
    logic                      wrap;
    logic                      last;
    logic                      accept;
    logic [CHANNELS*WIDTH-1:0] code_q;
    logic [CHANNELS*WIDTH-1:0] pending;

    assign n_next = n + WIDTH'(1);
    assign last   = en && wrap;
    assign accept = code_valid_i && code_ready_o;

    gray_slot_decode #(
        .WIDTH (WIDTH)
    ) u_decode (
        .n    (n),
        .slot (slot),
        .wrap (wrap)
    );

    // Slot counter advances only while enabled, wrapping naturally.
    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            n <= '0;
        end else if (en) begin
            n <= n_next;
        end
    end

    // Gray monitor tracks the counter value it will hold next cycle.
    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            gray_o <= '0;
        end else if (en) begin
            gray_o <= n_next ^ (n_next >> 1);
        end
    end

    // Pending/active code handshake; ready low means pending is full.
    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            code_q       <= '0;
            pending      <= '0;
            code_ready_o <= 1'b1;
        end else if (accept && last) begin
            code_q       <= code_i;
            code_ready_o <= 1'b1;
        end else if (accept) begin
            pending      <= code_i;
            code_ready_o <= 1'b0;
        end else if (last && !code_ready_o) begin
            code_q       <= pending;
            code_ready_o <= 1'b1;
        end
    end

    // Frame marker accompanies the output bit of slot 0.
    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            frame_start_o <= 1'b0;
        end else begin
            frame_start_o <= en && (n == '0);
        end
    end

    for (genvar c = 0; c < CHANNELS; c++) begin : g_chan
        logic [WIDTH-1:0] rev;
        logic             bit_sel;
        logic             pdm_q;

        // Slot position k selects code bit WIDTH-1-k.
        always_comb begin
            rev = '0;
            for (int i = 0; i < WIDTH; i++) begin
                rev[i] = code_q[c*WIDTH + WIDTH-1-i];
            end
            bit_sel = |(rev & slot);
        end

        // Registered output bit; forced low while disabled.
        always_ff @(posedge clk or negedge rstb) begin
            if (!rstb) begin
                pdm_q <= 1'b0;
            end else begin
                pdm_q <= en && (bit_sel ^ invert_i[c]);
            end
        end

        assign pdm_o[c] = pdm_q;
    end

endmodule

// File: tb/tb_gray_pdm_modulator.sv
// Randomized + directed bench for gray_pdm_modulator (W=4, C=2)
// against a slot-rule reference model.
module tb_gray_pdm_modulator;

    localparam int W = 4;
    localparam int C = 2;

    logic         clk = 1'b0;
    logic         rstb;
    logic         en;
    logic [C*W-1:0] code_i;
    logic         code_valid_i;
    logic         code_ready_o;
    logic [C-1:0] invert_i;
    logic [C-1:0] pdm_o;
    logic         frame_start_o;
    logic [W-1:0] gray_o;

    int n_vec = 0;
    int n_err = 0;

    logic [3:0]   m_n;
    logic [3:0]   m_code [C];
    logic [3:0]   m_pend [C];
    logic         m_full;
    logic [C-1:0] exp_pdm;
    logic         exp_fs;
    logic [3:0]   last_slot;

    gray_pdm_modulator #(
        .WIDTH    (W),
        .CHANNELS (C)
    ) dut (
        .clk           (clk),
        .rstb          (rstb),
        .en            (en),
        .code_i        (code_i),
        .code_valid_i  (code_valid_i),
        .code_ready_o  (code_ready_o),
        .invert_i      (invert_i),
        .pdm_o         (pdm_o),
        .frame_start_o (frame_start_o),
        .gray_o        (gray_o)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string nm, input logic [31:0] a,
                       input logic [31:0] e);
        n_vec++;
        if (a !== e) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t",
                     nm, a, e, $time);
        end
    endtask

    function automatic int tones(input logic [3:0] v);
        int k = 0;
        while (k < 4 && v[k]) k++;
        return k;
    endfunction

    // Spec rule: wrap slot carries 0, else code bit W-1-k.
    function automatic logic spec_bit(input logic [3:0] v,
                                      input logic [3:0] code);
        if (v == 4'hF) return 1'b0;
        return code[3 - tones(v)];
    endfunction

    function automatic logic [3:0] gray_of(input logic [3:0] v);
        return v ^ (v >> 1);
    endfunction

    task automatic model_reset();
        m_n    = '0;
        m_full = 1'b0;
        for (int c = 0; c < C; c++) begin
            m_code[c] = '0;
            m_pend[c] = '0;
        end
    endtask

    task automatic step(input logic e, input logic v,
                        input logic [3:0] c0, input logic [3:0] c1,
                        input logic [C-1:0] inv);
        logic       lst;
        logic       acc;
        logic [3:0] cin [C];
        @(negedge clk);
        en           = e;
        code_valid_i = v;
        code_i       = {c1, c0};
        invert_i     = inv;
        cin[0] = c0;
        cin[1] = c1;
        lst = e && (m_n == 4'hF);
        acc = v && !m_full;
        last_slot = m_n;
        for (int c = 0; c < C; c++)
            exp_pdm[c] = e && (spec_bit(m_n, m_code[c]) ^ inv[c]);
        exp_fs = e && (m_n == 4'h0);
        if (acc && lst) begin
            for (int c = 0; c < C; c++) m_code[c] = cin[c];
        end else if (acc) begin
            for (int c = 0; c < C; c++) m_pend[c] = cin[c];
            m_full = 1'b1;
        end else if (lst && m_full) begin
            for (int c = 0; c < C; c++) m_code[c] = m_pend[c];
            m_full = 1'b0;
        end
        if (e) m_n = m_n + 4'd1;
        @(posedge clk);
        #1;
        chk("pdm", 32'(pdm_o), 32'(exp_pdm));
        chk("frame_start", 32'(frame_start_o), 32'(exp_fs));
        chk("ready", 32'(code_ready_o), 32'(!m_full));
        chk("gray", 32'(gray_o), 32'(gray_of(m_n)));
    endtask

    task automatic do_reset();
        @(negedge clk);
        rstb         = 1'b0;
        en           = 1'b0;
        code_valid_i = 1'b0;
        #1;
        chk("rst_pdm", 32'(pdm_o), 32'h0);
        chk("rst_fs", 32'(frame_start_o), 32'h0);
        chk("rst_ready", 32'(code_ready_o), 32'h1);
        chk("rst_gray", 32'(gray_o), 32'h0);
        model_reset();
        @(negedge clk);
        rstb = 1'b1;
    endtask

    task automatic goto_slot(input logic [3:0] t);
        for (int i = 0; i < 40 && m_n != t; i++)
            step(1'b1, 1'b0, 4'h0, 4'h0, 2'b00);
        chk("goto_slot", 32'(m_n), 32'(t));
    endtask

    // Load codes during one frame, then capture the next frame's slots.
    task automatic run_frame(input logic [3:0] c0, input logic [3:0] c1,
                             input logic [C-1:0] inv,
                             output logic [15:0] k0,
                             output logic [15:0] k1);
        goto_slot(4'h0);
        for (int s = 0; s < 16; s++)
            step(1'b1, s == 0, c0, c1, inv);
        k0 = '0;
        k1 = '0;
        for (int s = 0; s < 16; s++) begin
            step(1'b1, 1'b0, 4'h0, 4'h0, inv);
            k0[last_slot] = pdm_o[0];
            k1[last_slot] = pdm_o[1];
        end
    endtask

    initial begin
        logic [15:0] k0, k1;
        rstb = 1'b1;
        en = 1'b0;
        code_valid_i = 1'b0;
        code_i = '0;
        invert_i = '0;
        model_reset();
        #3;
        do_reset();

        run_frame(4'd0, 4'd0, 2'b00, k0, k1);
        chk("mask_code0_c0", 32'(k0), 32'h0000);
        chk("mask_code0_c1", 32'(k1), 32'h0000);
        run_frame(4'd8, 4'd15, 2'b00, k0, k1);
        chk("mask_code8", 32'(k0), 32'h5555);
        chk("mask_code15", 32'(k1), 32'h7FFF);
        run_frame(4'd1, 4'd2, 2'b00, k0, k1);
        chk("mask_code1", 32'(k0), 32'h0080);
        chk("mask_code2", 32'(k1), 32'h0808);
        run_frame(4'd5, 4'd5, 2'b01, k0, k1);
        chk("mask_inv5", 32'(k0), 32'hDD5D);
        chk("ones_inv5", 32'($countones(k0)), 32'd11);
        chk("mask_code5", 32'(k1), 32'h22A2);

        // Offer at slot 5: ready low until the slot-15 edge.
        goto_slot(4'd5);
        step(1'b1, 1'b1, 4'd12, 4'd12, 2'b00);
        chk("ready_low_s5", 32'(code_ready_o), 32'h0);
        for (int s = 6; s < 15; s++) begin
            step(1'b1, 1'b1, 4'd7, 4'd7, 2'b00);
            chk("ready_stall", 32'(code_ready_o), 32'h0);
        end
        step(1'b1, 1'b0, 4'd0, 4'd0, 2'b00);
        chk("ready_back", 32'(code_ready_o), 32'h1);
        k0 = '0;
        for (int s = 0; s < 16; s++) begin
            step(1'b1, 1'b0, 4'd0, 4'd0, 2'b00);
            k0[last_slot] = pdm_o[0];
        end
        chk("ones_code12", 32'($countones(k0)), 32'd12);

        // Offer exactly at slot 15: ready stays high.
        goto_slot(4'd15);
        step(1'b1, 1'b1, 4'd3, 4'd3, 2'b00);
        chk("ready_s15", 32'(code_ready_o), 32'h1);
        k1 = '0;
        for (int s = 0; s < 16; s++) begin
            step(1'b1, 1'b0, 4'd0, 4'd0, 2'b00);
            k1[last_slot] = pdm_o[1];
        end
        chk("ones_code3", 32'($countones(k1)), 32'd3);

        // Freeze at slot 9.
        goto_slot(4'd9);
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 1'b0, 4'd0, 4'd0, 2'b11);
            chk("frozen_pdm", 32'(pdm_o), 32'h0);
            chk("frozen_gray", 32'(gray_o), 32'hD);
        end
        step(1'b1, 1'b0, 4'd0, 4'd0, 2'b00);
        chk("resume_gray", 32'(gray_o), 32'hF);

        // Reset mid-frame at slot 6, restart from slot 0 with code 0.
        goto_slot(4'd6);
        do_reset();
        step(1'b1, 1'b0, 4'd0, 4'd0, 2'b00);
        chk("restart_fs", 32'(frame_start_o), 32'h1);
        k0 = 16'h0;
        for (int s = 1; s < 16; s++) begin
            step(1'b1, 1'b0, 4'd0, 4'd0, 2'b00);
            k0[last_slot] = pdm_o[0] | pdm_o[1];
        end
        chk("restart_zero", 32'(k0), 32'h0);

        // Randomized traffic, every cycle checked by the model.
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 399) == 0) begin
                do_reset();
            end else begin
                step($urandom_range(0, 9) != 0,
                     $urandom_range(0, 3) == 0,
                     4'($urandom), 4'($urandom),
                     2'($urandom));
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
